// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared float field layout and one-hot status encoding
package fpu_pkg;

    localparam int EXP_W    = 6;
    localparam int FRAC_W   = 25;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 25;

    typedef enum logic [3:0] {
        EXACT     = 4'b0001,
        INEXACT   = 4'b0010,
        OVERFLOW  = 4'b0100,
        UNDERFLOW = 4'b1000
    } status_t;

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - 32-bit leading-zero counter, returns 32 for an all-zero word
module lzc32 (
    input  logic [31:0] data_i,
    output logic [5:0]  count_o
);

    // Scan upward so the highest set bit is the last one to update the count
    always_comb begin
        count_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (data_i[i]) begin
                count_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_fpu_encoder.sv
// rtl/int_to_fpu_encoder.sv - integer to FPU float encoder; optional INT2FPU_FAST_NORM_EN
module int_to_fpu_encoder
    import fpu_pkg::*;
#(
    parameter int BIAS      = 31,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [31:0] int_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] data_out,
    output logic [3:0]  status_out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [5:0]  lz_q, lz_d;
    logic        sign_q, sign_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  status_q, status_d;
    logic        out_valid_q, out_valid_d;

    logic              accept;
    logic              in_neg;
    logic [31:0]       in_mag;
    logic [6:0]        exp_raw;
    logic [6:0]        exp_rnd;
    logic [FRAC_W:0]   frac_sum;
    logic [FRAC_W-1:0] frac_rnd;
    logic              guard;
    logic              sticky;

    assign in_ready   = (state_q == S_IDLE) && reset;
    assign accept     = in_valid && in_ready;
    assign data_out   = data_q;
    assign status_out = status_q;
    assign out_valid  = out_valid_q;

    // mag_q holds the raw operand while in ABS; -2^31 negates onto itself
    assign in_neg = SIGNED_IN & mag_q[31];
    assign in_mag = in_neg ? (~mag_q + 32'd1) : mag_q;

    // Round to nearest, ties away from zero; a fraction carry bumps the exponent
    assign exp_raw  = 7'(BIAS) + 7'd31 - {1'b0, lz_q};
    assign guard    = mag_q[5];
    assign sticky   = |mag_q[4:0];
    assign frac_sum = {1'b0, mag_q[30:6]} + {{FRAC_W{1'b0}}, guard};
    assign frac_rnd = frac_sum[FRAC_W-1:0];
    assign exp_rnd  = exp_raw + {6'd0, frac_sum[FRAC_W]};

`ifdef INT2FPU_FAST_NORM_EN
    logic [5:0] lz_cnt;

    lzc32 u_lzc32 (
        .data_i  (mag_q),
        .count_o (lz_cnt)
    );
`endif

    // Next-state, datapath and output register updates
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        lz_d        = lz_q;
        sign_d      = sign_q;
        data_d      = data_q;
        status_d    = status_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mag_d   = int_in;
                    lz_d    = 6'd0;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                sign_d = in_neg;
                mag_d  = in_mag;
                if (in_mag == 32'd0) begin
                    data_d      = 32'd0;
                    status_d    = EXACT;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
`ifdef INT2FPU_FAST_NORM_EN
                mag_d   = mag_q << lz_cnt;
                lz_d    = lz_cnt;
                state_d = S_ROUND;
`else
                if (mag_q[31]) begin
                    state_d = S_ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    lz_d  = lz_q + 6'd1;
                end
`endif
            end
            S_ROUND: begin
                data_d[SIGN_BIT]        = sign_q;
                data_d[EXP_MSB:EXP_LSB] = exp_rnd[EXP_W-1:0];
                data_d[FRAC_W-1:0]      = frac_rnd;
                if (exp_rnd > 7'd63) begin
                    data_d   = 32'd0;
                    status_d = OVERFLOW;
                end else if (exp_rnd == 7'd0) begin
                    status_d = UNDERFLOW;
                end else if (guard || sticky) begin
                    status_d = INEXACT;
                end else begin
                    status_d = EXACT;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear
    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mag_q       <= 32'd0;
            lz_q        <= 6'd0;
            sign_q      <= 1'b0;
            data_q      <= 32'd0;
            status_q    <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            lz_q        <= lz_d;
            sign_q      <= sign_d;
            data_q      <= data_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
